// File: rtl/uart_tx_chunk_arbiter_if.sv
// Purpose: bundles requester-side and chunker-side signals of the chunk arbiter.
// Latency: none (pure wiring).
// Backpressure: level valid held until one-cycle ack; chunker_done gates every grant.
interface uart_tx_chunk_arbiter_if #(
    parameter int NUM_REQUESTERS    = 2,
    parameter int GRANT_WIDTH       = 1,
    parameter int BUFFER_BYTE_SIZE  = 3,
    parameter int BUFFER_INDEX_SIZE = 32
);
    logic [NUM_REQUESTERS-1:0]                   req_valid;
    logic [NUM_REQUESTERS*BUFFER_INDEX_SIZE-1:0] req_byte_size;
    logic [NUM_REQUESTERS*BUFFER_BYTE_SIZE*8-1:0] req_bytes;
    logic [NUM_REQUESTERS*8-1:0]                 req_type;
    logic [NUM_REQUESTERS-1:0]                   req_ack;
    logic [NUM_REQUESTERS-1:0]                   req_reject;
    logic [NUM_REQUESTERS-1:0]                   req_done;
    logic                                        chunk_ready;
    logic [BUFFER_INDEX_SIZE-1:0]                chunk_byte_size;
    logic [BUFFER_BYTE_SIZE*8-1:0]               chunk_bytes;
    logic [7:0]                                  chunk_type;
    logic                                        chunker_done;
    logic                                        busy;
    logic [GRANT_WIDTH-1:0]                      grant_id;

    // Arbiter view.
    modport slave (
        input  req_valid, req_byte_size, req_bytes, req_type, chunker_done,
        output req_ack, req_reject, req_done, chunk_ready, chunk_byte_size,
               chunk_bytes, chunk_type, busy, grant_id
    );

    // Requester/chunker view.
    modport master (
        output req_valid, req_byte_size, req_bytes, req_type, chunker_done,
        input  req_ack, req_reject, req_done, chunk_ready, chunk_byte_size,
               chunk_bytes, chunk_type, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_chunk_arbiter.sv
// Purpose: round-robin share of one typed chunker among several chunk requesters.
// Latency: valid seen in IDLE with chunker idle -> ack and chunk_ready next cycle.
// Backpressure: no grant while chunker_done is low; losers hold valid until granted.
module uart_tx_chunk_arbiter #(
    parameter int NUM_REQUESTERS    = 2,
    parameter int GRANT_WIDTH       = 1,
    parameter int BUFFER_BYTE_SIZE  = 3,
    parameter int BUFFER_INDEX_SIZE = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    uart_tx_chunk_arbiter_if.slave bus
);
    localparam int PW = BUFFER_BYTE_SIZE * 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [GRANT_WIDTH-1:0]        grant_id_q;
    logic [NUM_REQUESTERS-1:0]     ack_q;
    logic [NUM_REQUESTERS-1:0]     reject_q;
    logic [NUM_REQUESTERS-1:0]     done_q;
    logic [BUFFER_INDEX_SIZE-1:0]  size_q;
    logic [PW-1:0]                 bytes_q;
    logic [7:0]                    type_q;

    logic                          hi_found;
    logic                          lo_found;
    logic [GRANT_WIDTH-1:0]        hi_sel;
    logic [GRANT_WIDTH-1:0]        lo_sel;
    logic                          sel_found;
    logic [GRANT_WIDTH-1:0]        sel;
    logic [NUM_REQUESTERS-1:0]     sel_onehot;
    logic [NUM_REQUESTERS-1:0]     gid_onehot;
    logic [BUFFER_INDEX_SIZE-1:0]  sel_size;
    logic [PW-1:0]                 sel_bytes;
    logic [7:0]                    sel_type;
    logic                          sel_ok;
    logic                          grant;

    // Round-robin pick: first valid index above the last grant, else first valid from 0.
    always_comb begin
        hi_found   = 1'b0;
        lo_found   = 1'b0;
        hi_sel     = '0;
        lo_sel     = '0;
        sel_onehot = '0;
        gid_onehot = '0;
        sel_size   = '0;
        sel_bytes  = '0;
        sel_type   = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (!hi_found && bus.req_valid[i] && (i > int'(grant_id_q))) begin
                hi_found = 1'b1;
                hi_sel   = GRANT_WIDTH'(i);
            end
            if (!lo_found && bus.req_valid[i]) begin
                lo_found = 1'b1;
                lo_sel   = GRANT_WIDTH'(i);
            end
        end
        sel_found = hi_found || lo_found;
        sel       = hi_found ? hi_sel : lo_sel;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            sel_onehot[i] = (GRANT_WIDTH'(i) == sel);
            gid_onehot[i] = (GRANT_WIDTH'(i) == grant_id_q);
            if (GRANT_WIDTH'(i) == sel) begin
                sel_size  = bus.req_byte_size[i*BUFFER_INDEX_SIZE +: BUFFER_INDEX_SIZE];
                sel_bytes = bus.req_bytes[i*PW +: PW];
                sel_type  = bus.req_type[i*8 +: 8];
            end
        end
        // Size 0, oversize and type 0 would make the chunker misbehave.
        sel_ok = (sel_size != '0) &&
                 (sel_size <= BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE)) &&
                 (sel_type != 8'd0);
        grant  = (state == IDLE) && bus.chunker_done && sel_found;
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; HOLD spans the reject pulse cycle plus one settle cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant) state_nxt = sel_ok ? ISSUE : HOLD;
            ISSUE:     if (!bus.chunker_done) state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.chunker_done) state_nxt = IDLE;
            HOLD:      if (reject_q == '0) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs; the start strobe drops as soon as the chunker leaves idle.
    always_comb begin
        bus.chunk_ready = (state == ISSUE) && bus.chunker_done;
        bus.busy        = (state != IDLE);
    end

    // Capture registers, grant pointer and one-cycle handshake pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            grant_id_q <= GRANT_WIDTH'(NUM_REQUESTERS - 1);
            ack_q      <= '0;
            reject_q   <= '0;
            done_q     <= '0;
            size_q     <= '0;
            bytes_q    <= '0;
            type_q     <= '0;
        end else begin
            ack_q    <= '0;
            reject_q <= '0;
            done_q   <= '0;
            if (grant) begin
                grant_id_q <= sel;
                size_q     <= sel_size;
                bytes_q    <= sel_bytes;
                type_q     <= sel_type;
                ack_q      <= sel_onehot;
                if (!sel_ok) begin
                    reject_q <= sel_onehot;
                end
            end
            if ((state == WAIT_DONE) && bus.chunker_done) begin
                done_q <= gid_onehot;
            end
        end
    end

    assign bus.req_ack         = ack_q;
    assign bus.req_reject      = reject_q;
    assign bus.req_done        = done_q;
    assign bus.chunk_byte_size = size_q;
    assign bus.chunk_bytes     = bytes_q;
    assign bus.chunk_type      = type_q;
    assign bus.grant_id        = grant_id_q;
endmodule
